// File: rtl/sevenseg_scan.sv
// sevenseg_scan: time-multiplexed hex driver for a bank of common-anode
// seven-segment digits.
//
// A double-buffered display value (shadow -> active) is committed only on a
// frame wrap, so a frame never mixes two values. One digit is lit at a time
// for PRESCALE clk cycles. Nibbles decode to active-low segments.
//
// Optional feature: define SEVENSEG_SCAN_LZB_EN for leading-zero blanking.
// Digits above the most significant nonzero nibble go dark, digit 0 never.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   load            one-cycle strobe capturing value_in/dp_in/blank_in
//   value_in        nibble i = digit i (digit 0 rightmost)
//   dp_in           1 = decimal point lit for digit i
//   blank_in        1 = digit i forced dark
//   out_ssd         segments g..a, active-low (7F = dark)
//   out_dp          decimal point, active-low
//   digit_en        one-hot digit enable, polarity per ANODE_ACTIVE_LOW
//   pending         shadow holds a value not yet displayed
//   frame_done      one-cycle pulse after the scan wraps to digit 0
module sevenseg_scan #(
  parameter int NUM_DIGITS       = 4,
  parameter int PRESCALE         = 50000,
  parameter int ANODE_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic [6:0]              out_ssd,
  output logic                    out_dp,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    pending,
  output logic                    frame_done
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PCNT_MAX = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_MAX  = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] EN_OFF =
    (ANODE_ACTIVE_LOW != 0) ? '1 : '0;

  logic [PW-1:0] pcnt;
  logic [IW-1:0] idx;
  logic          tick, wrap;

  logic [NUM_DIGITS-1:0][3:0] sh_val, act_val;
  logic [NUM_DIGITS-1:0]      sh_dp, sh_blank, act_dp, act_blank;
  logic [NUM_DIGITS-1:0]      lz, onehot;
  logic                       dark;
  logic [3:0]                 nib;

  assign tick = (pcnt == PCNT_MAX);
  assign wrap = tick && (idx == IDX_MAX);

  function automatic logic [6:0] seg7(input logic [3:0] x);
    case (x)
      4'h0: seg7 = 7'h40; 4'h1: seg7 = 7'h79; 4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30; 4'h4: seg7 = 7'h19; 4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02; 4'h7: seg7 = 7'h78; 4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10; 4'hA: seg7 = 7'h08; 4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46; 4'hD: seg7 = 7'h21; 4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  // Leading-zero mask: a digit is dark while every nibble at or above it is 0.
`ifdef SEVENSEG_SCAN_LZB_EN
  always_comb begin
    logic seen;
    lz   = '0;
    seen = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      seen  = seen | (act_val[i] != 4'h0);
      lz[i] = !seen;
    end
  end
`else
  assign lz = '0;
`endif

  assign nib    = act_val[idx];
  assign dark   = act_blank[idx] | lz[idx];
  assign onehot = NUM_DIGITS'(1) << idx;

  // Scan counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
      idx  <= '0;
    end else begin
      pcnt <= tick ? '0 : pcnt + PW'(1);
      if (wrap)      idx <= '0;
      else if (tick) idx <= idx + IW'(1);
    end
  end

  // Double buffer. A load coinciding with the wrap bypasses the shadow so the
  // newest value is never left stranded behind a stale commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_val    <= '0;
      sh_dp     <= '0;
      sh_blank  <= '0;
      act_val   <= '0;
      act_dp    <= '0;
      act_blank <= '0;
      pending   <= 1'b0;
    end else begin
      if (load) begin
        sh_val   <= value_in;
        sh_dp    <= dp_in;
        sh_blank <= blank_in;
      end
      if (wrap && load) begin
        act_val   <= value_in;
        act_dp    <= dp_in;
        act_blank <= blank_in;
      end else if (wrap && pending) begin
        act_val   <= sh_val;
        act_dp    <= sh_dp;
        act_blank <= sh_blank;
      end
      if (wrap)      pending <= 1'b0;
      else if (load) pending <= 1'b1;
    end
  end

  // Registered display outputs for the digit currently indexed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_ssd    <= 7'h7F;
      out_dp     <= 1'b1;
      digit_en   <= EN_OFF;
      frame_done <= 1'b0;
    end else begin
      out_ssd    <= dark ? 7'h7F : seg7(nib);
      out_dp     <= dark | ~act_dp[idx];
      digit_en   <= (ANODE_ACTIVE_LOW != 0) ? ~onehot : onehot;
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan.sv
// Testbench for sevenseg_scan. Two instances (PRESCALE=3 and PRESCALE=1,
// both 4 digits, active-low anodes) share stimulus. Expected outputs come
// from a frame-level model: after the n-th clock edge since reset release,
// digit ((n-1)/P)%4 of the value loaded at or before the start of frame
// (n-1)/(4P) is shown.
module tb_sevenseg_scan;
  localparam int N = 4;

  logic        clk = 1'b0, rst_n = 1'b0, load = 1'b0;
  logic [15:0] value_in = '0;
  logic [3:0]  dp_in = '0, blank_in = '0;
  logic [6:0]  a_ssd, b_ssd;
  logic        a_dp, b_dp, a_pend, b_pend, a_fd, b_fd;
  logic [3:0]  a_en, b_en;

  sevenseg_scan #(.NUM_DIGITS(N), .PRESCALE(3), .ANODE_ACTIVE_LOW(1)) u_a (
    .clk(clk), .rst_n(rst_n), .load(load), .value_in(value_in),
    .dp_in(dp_in), .blank_in(blank_in), .out_ssd(a_ssd), .out_dp(a_dp),
    .digit_en(a_en), .pending(a_pend), .frame_done(a_fd));

  sevenseg_scan #(.NUM_DIGITS(N), .PRESCALE(1), .ANODE_ACTIVE_LOW(1)) u_b (
    .clk(clk), .rst_n(rst_n), .load(load), .value_in(value_in),
    .dp_in(dp_in), .blank_in(blank_in), .out_ssd(b_ssd), .out_dp(b_dp),
    .digit_en(b_en), .pending(b_pend), .frame_done(b_fd));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] ssd;
    logic       dp;
    logic [3:0] en;
    logic       pend;
    logic       fd;
  } obs_t;

  typedef struct {
    int          e;
    logic [15:0] v;
    logic [3:0]  dp;
    logic [3:0]  bl;
  } ld_t;

  ld_t lq[$];
  int  n;
  int  checks   = 0;
  int  failures = 0;
  obs_t oa, ob, ea, eb;

  function automatic logic [6:0] hexseg(input logic [3:0] x);
    logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02,
                           7'h78, 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21,
                           7'h06, 7'h0E};
    return t[x];
  endfunction

  function automatic obs_t model(input int p);
    obs_t        r;
    int          np, d, f, w, h;
    logic [15:0] v;
    logic [3:0]  dpv, blv, one, x;
    logic        dark;
    r = '{ssd: 7'h7F, dp: 1'b1, en: 4'hF, pend: 1'b0, fd: 1'b0};
    if (n == 0) return r;
    np = N * p;
    d  = ((n - 1) / p) % N;
    f  = (n - 1) / np;
    v = '0; dpv = '0; blv = '0;
    foreach (lq[i]) if (lq[i].e <= f * np) begin
      v = lq[i].v; dpv = lq[i].dp; blv = lq[i].bl;
    end
    h = -1;
    for (int i = 0; i < N; i++) if (((v >> (4 * i)) & 16'hF) != 0) h = i;
    dark = blv[d];
`ifdef SEVENSEG_SCAN_LZB_EN
    if (d > 0 && d > h) dark = 1'b1;
`endif
    x     = 4'((v >> (4 * d)) & 16'hF);
    one   = 4'b0001;
    r.ssd = dark ? 7'h7F : hexseg(x);
    r.dp  = dark ? 1'b1 : ~dpv[d];
    r.en  = ~(one << d);
    w      = (n / np) * np;
    r.pend = (lq.size() > 0) && (lq[lq.size() - 1].e > w);
    r.fd   = (n % np) == 0;
    return r;
  endfunction

  function automatic obs_t get_a();
    return '{ssd: a_ssd, dp: a_dp, en: a_en, pend: a_pend, fd: a_fd};
  endfunction
  function automatic obs_t get_b();
    return '{ssd: b_ssd, dp: b_dp, en: b_en, pend: b_pend, fd: b_fd};
  endfunction

  // One clock edge; observation happens 1 time unit after the edge.
  task automatic step(input logic ld, input logic [15:0] v,
                      input logic [3:0] dp, input logic [3:0] bl);
    load = ld; value_in = v; dp_in = dp; blank_in = bl;
    @(posedge clk);
    n++;
    if (ld) lq.push_back('{e: n, v: v, dp: dp, bl: bl});
    #1;
    load = 1'b0;
    oa = get_a(); ob = get_b(); ea = model(3); eb = model(1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    lq.delete();
    n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    lq.delete();
    n = 0;
    repeat (2) @(posedge clk);
    #1;
    oa = get_a(); ob = get_b(); ea = model(3); eb = model(1);
    checks++;
    if (oa !== ea) begin failures++; $display("FAIL reset_a got=%h want=%h", oa, ea); end
    checks++;
    if (ob !== eb) begin failures++; $display("FAIL reset_b got=%h want=%h", ob, eb); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_first_value();
    do_reset();
    for (int c = 0; c < 40; c++) begin
      step(c == 0, 16'h12AF, 4'h0, 4'h0);
      checks++;
      if (oa !== ea) begin failures++; $display("FAIL first_a n=%0d got=%h want=%h", n, oa, ea); end
      checks++;
      if (ob !== eb) begin failures++; $display("FAIL first_b n=%0d got=%h want=%h", n, ob, eb); end
    end
  endtask

  task automatic test_overwrite();
    do_reset();
    for (int c = 1; c <= 40; c++) begin
      step(c == 5 || c == 7, (c == 5) ? 16'h1111 : 16'h2222, 4'h0, 4'h0);
      checks++;
      if (oa !== ea) begin failures++; $display("FAIL overwrite_a n=%0d got=%h want=%h", n, oa, ea); end
      checks++;
      if (ob !== eb) begin failures++; $display("FAIL overwrite_b n=%0d got=%h want=%h", n, ob, eb); end
    end
  endtask

  task automatic test_wrap_load();
    do_reset();
    // edge 12 is a frame wrap for both P=3 (12 cycles) and P=1 (4 cycles)
    for (int c = 1; c <= 36; c++) begin
      step(c == 12, 16'h0F0F, 4'h0, 4'h0);
      checks++;
      if (oa !== ea) begin failures++; $display("FAIL wrapload_a n=%0d got=%h want=%h", n, oa, ea); end
      checks++;
      if (ob !== eb) begin failures++; $display("FAIL wrapload_b n=%0d got=%h want=%h", n, ob, eb); end
    end
  endtask

  task automatic test_blank_dp();
    do_reset();
    for (int c = 1; c <= 30; c++) begin
      step(c == 2, 16'h9876, 4'b0001, 4'b0100);
      checks++;
      if (oa !== ea) begin failures++; $display("FAIL blankdp_a n=%0d got=%h want=%h", n, oa, ea); end
      checks++;
      if (ob !== eb) begin failures++; $display("FAIL blankdp_b n=%0d got=%h want=%h", n, ob, eb); end
    end
  endtask

  task automatic test_lzb();
    do_reset();
    for (int c = 1; c <= 60; c++) begin
      step(c == 1 || c == 30, (c == 1) ? 16'h0030 : 16'h0000, 4'h0, 4'h0);
      checks++;
      if (oa !== ea) begin failures++; $display("FAIL lzb_a n=%0d got=%h want=%h", n, oa, ea); end
      checks++;
      if (ob !== eb) begin failures++; $display("FAIL lzb_b n=%0d got=%h want=%h", n, ob, eb); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    // value committed at edge 12, then a fresh load leaves pending high
    for (int c = 1; c <= 20; c++) step(c == 1 || c == 19, 16'h4321 + 16'(c), 4'h3, 4'h0);
    #2;
    rst_n = 1'b0;
    lq.delete();
    n = 0;
    #1;
    oa = get_a(); ob = get_b(); ea = model(3); eb = model(1);
    checks++;
    if (oa !== ea) begin failures++; $display("FAIL midreset_a got=%h want=%h", oa, ea); end
    checks++;
    if (ob !== eb) begin failures++; $display("FAIL midreset_b got=%h want=%h", ob, eb); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      step(1'b0, 16'h0, 4'h0, 4'h0);
      checks++;
      if (oa !== ea) begin failures++; $display("FAIL postreset_a n=%0d got=%h want=%h", n, oa, ea); end
      checks++;
      if (ob !== eb) begin failures++; $display("FAIL postreset_b n=%0d got=%h want=%h", n, ob, eb); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      step(($urandom_range(0, 7) == 0), 16'($urandom), 4'($urandom), 4'($urandom));
      checks++;
      if (oa !== ea) begin failures++; $display("FAIL random_a n=%0d got=%h want=%h", n, oa, ea); end
      checks++;
      if (ob !== eb) begin failures++; $display("FAIL random_b n=%0d got=%h want=%h", n, ob, eb); end
    end
  endtask

  initial begin
    test_reset();
    test_first_value();
    test_overwrite();
    test_wrap_load();
    test_blank_dp();
    test_lzb();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
